sw_change_detect: RTL and testbench

- Front-end stage feeding the level/sequence checker's `change` input.
- Synchronises and debounces the player's slide switches, then detects which switch toggled (either direction).
- Presents that switch's index as a 4-bit code, held long enough for the checker's slow 0.5 s sampling tick; 4'hF means "no change".
- Sits directly between the board switches and the checker.

---
 rtl/sw_change_detect.sv | 200 ++++++++++++++++++++
 tb/tb_sw_change_detect.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_change_detect.sv
// sw_change_detect: synchronise and debounce slide switches, report the lowest toggled index on `change` (4'hF = none).
// Define SWDET_QUEUE_EN to queue toggles seen during HOLD/GAP (4 deep) and add a sticky `overflow` output.
module sw_change_detect #(
  parameter int NUM_SW      = 10,
  parameter int DEBOUNCE    = 20,
  parameter int HOLD_CYCLES = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_SW-1:0] sw,
  input  logic              ack,
  output logic [3:0]        change,
  output logic              pending,
  output logic              multi_err
`ifdef SWDET_QUEUE_EN
  ,
  output logic              overflow
`endif
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PW = $clog2(DEBOUNCE + 3);

  typedef enum logic [1:0] {PRIME, IDLE, HOLD, GAP} state_t;
  state_t state, state_nxt;

  logic [NUM_SW-1:0] sync1, sync2, deb, deb_prev, toggle;
  logic [DW-1:0]     dcnt [NUM_SW];
  logic [PW-1:0]     pcnt;
  logic [HW-1:0]     hcnt;
  logic [3:0]        idx, low_idx, load_idx;
  logic              fire, multi, load;

`ifdef SWDET_QUEUE_EN
  logic [3:0] q_mem [4];
  logic [1:0] q_rd, q_wr;
  logic [2:0] q_cnt;
  logic       push, pop, push_ok, q_any;
  logic [3:0] q_head;

  assign q_any   = (q_cnt != 3'd0);
  assign q_head  = q_mem[q_rd];
  assign push_ok = push && (q_cnt != 3'd4);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // PRIME copies the synchroniser straight through so power-up levels never look like toggles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < NUM_SW; i++) dcnt[i] <= '0;
    end else if (state == PRIME) begin
      deb      <= sync2;
      deb_prev <= sync2;
      for (int i = 0; i < NUM_SW; i++) dcnt[i] <= '0;
    end else begin
      deb_prev <= deb;
      for (int i = 0; i < NUM_SW; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE)) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign toggle = deb ^ deb_prev;
  assign multi  = |(toggle & (toggle - NUM_SW'(1)));
  assign fire   = enable && (|toggle);

  always_comb begin
    low_idx = 4'hF;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (toggle[i]) low_idx = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PRIME;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_idx  = low_idx;
`ifdef SWDET_QUEUE_EN
    push      = 1'b0;
    pop       = 1'b0;
`endif
    case (state)
      PRIME: if (pcnt == PW'(DEBOUNCE + 1)) state_nxt = IDLE;
      IDLE: begin
`ifdef SWDET_QUEUE_EN
        // A queued event beats a fresh toggle; the fresh one goes to the back of the queue.
        if (q_any) begin
          pop       = 1'b1;
          load      = 1'b1;
          load_idx  = q_head;
          push      = fire;
          state_nxt = HOLD;
        end else
`endif
        if (fire) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ack || hcnt == '0) state_nxt = GAP;
`ifdef SWDET_QUEUE_EN
        push = fire;
`endif
      end
      GAP: begin
        state_nxt = IDLE;
`ifdef SWDET_QUEUE_EN
        push = fire;
        if (q_any) begin
          pop       = 1'b1;
          load      = 1'b1;
          load_idx  = q_head;
          state_nxt = HOLD;
        end
`endif
      end
      default: state_nxt = PRIME;
    endcase
  end

  always_comb begin
    change    = 4'hF;
    pending   = 1'b0;
    multi_err = enable && multi && (state != PRIME);
    if (state == HOLD) begin
      change  = idx;
      pending = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (state == PRIME) begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      idx  <= '0;
    end else if (load) begin
      hcnt <= HW'(HOLD_CYCLES - 1);
      idx  <= load_idx;
    end else if (state == HOLD && hcnt != '0) begin
      hcnt <= hcnt - 1'b1;
    end
  end

`ifdef SWDET_QUEUE_EN
  always_ff @(posedge clk) begin
    if (push_ok) q_mem[q_wr] <= low_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_rd     <= '0;
      q_wr     <= '0;
      q_cnt    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)             q_rd     <= q_rd + 2'd1;
      if (push_ok)         q_wr     <= q_wr + 2'd1;
      if (push && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   q_cnt <= q_cnt + 3'd1;
        2'b01:   q_cnt <= q_cnt - 3'd1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sw_change_detect.sv
// Bench for sw_change_detect: directed steps then random switch activity against a sample-history reference model.
module tb_sw_change_detect;
  localparam int NUM_SW = 10;
  localparam int DEB    = 4;
  localparam int HOLD   = 2000;
  localparam int MAXE   = 20000;
`ifdef SWDET_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              en    = 1'b1;
  logic [NUM_SW-1:0] sw    = '0;
  logic              ack   = 1'b0;
  logic [3:0]        change;
  logic              pending, multi_err;
`ifdef SWDET_QUEUE_EN
  logic              overflow;
`endif

  int checks = 0, failures = 0;
  int ev_seen = 0, multi_cnt = 0;

  sw_change_detect #(.NUM_SW(NUM_SW), .DEBOUNCE(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(rst_n), .enable(en), .sw(sw), .ack(ack),
    .change(change), .pending(pending), .multi_err(multi_err)
`ifdef SWDET_QUEUE_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model. hist[n] is the raw level seen at the n-th edge after reset release (hist[0] = cleared synchroniser).
  // A switch's debounced level flips at edge m when raw samples m-DEB-2 .. m-2 all disagree with it.
  logic [NUM_SW-1:0] hist [0:MAXE];
  logic [NUM_SW-1:0] m_deb = '0, m_flip = '0;
  logic [3:0]        code = 4'hF, mlow;
  logic [3:0]        q [$];
  int                n = 0, start = 0, gap_edge = 0;
  bit                active = 0, m_ovf = 0;
  bit                mh, mg, mi, mf, mfull, alld;

  function automatic logic [3:0] lowest(input logic [NUM_SW-1:0] v);
    for (int i = 0; i < NUM_SW; i++) if (v[i]) return 4'(i);
    return 4'hF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; hist[0] = '0; active = 0; m_ovf = 0; m_deb = '0; m_flip = '0;
      start = 0; gap_edge = 0; q.delete();
    end else if (n < MAXE) begin
      n = n + 1;
      hist[n] = sw;
      mh = active && (start <= n - 1) && (n - 1 < gap_edge);
      mg = active && (n - 1 == gap_edge);
      mi = (n > DEB + 2) && !mh && !mg;
      mf = en && (m_flip != '0);
      mlow = lowest(m_flip);
      mfull = (q.size() >= 4);
      if (mh && ack) gap_edge = n;
      if ((mi || mg) && q.size() > 0) begin
        code = q.pop_front(); start = n; gap_edge = n + HOLD; active = 1;
      end else if (mi && mf) begin
        code = mlow; start = n; gap_edge = n + HOLD; active = 1; mf = 0;
      end
      if (QEN && mf) begin
        if (mfull) m_ovf = 1;
        else q.push_back(mlow);
      end
      if (n <= DEB + 2) begin
        m_deb  = (n >= 2) ? hist[n-2] : '0;
        m_flip = '0;
      end else begin
        m_flip = '0;
        for (int i = 0; i < NUM_SW; i++) begin
          alld = 1;
          for (int j = n - DEB - 2; j <= n - 2; j++) if (hist[j][i] == m_deb[i]) alld = 0;
          m_flip[i] = alld;
        end
        m_deb = m_deb ^ m_flip;
      end
    end
  end

  task automatic check_all(input string tag);
    logic [3:0] ec;
    logic       ep, em;
    ep = active && (start <= n) && (n < gap_edge);
    ec = ep ? code : 4'hF;
    em = en && ($countones(m_flip) > 1);
    checks++;
    assert (change === ec) else begin
      failures++; $error("FAIL %s change got=%h exp=%h", tag, change, ec);
    end
    checks++;
    assert (pending === ep) else begin
      failures++; $error("FAIL %s pending got=%b exp=%b", tag, pending, ep);
    end
    checks++;
    assert (multi_err === em) else begin
      failures++; $error("FAIL %s multi_err got=%b exp=%b", tag, multi_err, em);
    end
`ifdef SWDET_QUEUE_EN
    checks++;
    assert (overflow === m_ovf) else begin
      failures++; $error("FAIL %s overflow got=%b exp=%b", tag, overflow, m_ovf);
    end
`endif
    if (pending === 1'b1) ev_seen++;
    if (multi_err === 1'b1) multi_cnt++;
  endtask

  task automatic cycles(input int k, input string tag);
    for (int c = 0; c < k; c++) begin
      @(posedge clk); #1;
      check_all(tag);
    end
  endtask

  task automatic wait_pending(input int budget, input string tag, output int lat);
    lat = 0;
    do begin
      cycles(1, tag);
      lat++;
    end while (pending !== 1'b1 && lat < budget);
    checks++;
    assert (pending === 1'b1) else begin
      failures++; $error("FAIL %s_timeout pending got=%b exp=1 after %0d cycles", tag, pending, lat);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      failures++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int lat, cnt;
    logic [3:0] qlist [5];
    logic [3:0] after_gap;
    qlist = '{4'd5, 4'd6, 4'd8, 4'd3, 4'd2};

    // Switches all high through power-up: nothing must be reported.
    rst_n = 1'b0; sw = '1; en = 1'b1; ack = 1'b0;
    cycles(3, "reset");
    @(negedge clk); rst_n = 1'b1;
    ev_seen = 0;
    cycles(30, "prime_high");
    expect_int("prime_no_event", ev_seen, 0);

    @(negedge clk); rst_n = 1'b0; sw = '0;
    cycles(2, "reset2");
    @(negedge clk); rst_n = 1'b1;
    cycles(12, "idle");

    // Edge k is the first sampled edge, so `change` lands on the (DEB+4)-th edge counted from 1.
    @(negedge clk); sw[3] = 1'b1;
    wait_pending(20, "latency", lat);
    expect_int("latency_edges", lat, DEB + 4);
    expect_int("code_sw3", int'(change), 3);
    cnt = 0;
    while (pending === 1'b1 && cnt < HOLD + 10) begin
      cycles(1, "hold");
      cnt++;
    end
    expect_int("hold_len", cnt, HOLD);
    cycles(2, "gap_idle");

    ev_seen = 0;
    @(negedge clk); sw[5] = 1'b1;
    cycles(3, "glitch");
    @(negedge clk); sw[5] = 1'b0;
    cycles(20, "glitch_after");
    expect_int("glitch_no_event", ev_seen, 0);

    multi_cnt = 0;
    @(negedge clk); sw[2] = 1'b1; sw[7] = 1'b1;
    wait_pending(20, "multi", lat);
    expect_int("multi_code", int'(change), 2);
    cycles(5, "multi_hold");
    expect_int("multi_pulses", multi_cnt, 1);
    @(negedge clk); ack = 1'b1;
    cycles(1, "ack");
    expect_int("ack_ends_hold", int'(change), 15);
    @(negedge clk); ack = 1'b0;
    ev_seen = 0;
    cycles(20, "no_sw7");
    expect_int("sw7_dropped", ev_seen, 0);

    @(negedge clk); sw[4] = 1'b1;
    wait_pending(20, "sw4", lat);
    expect_int("code_sw4", int'(change), 4);
    cycles(5, "sw4_hold");
    @(negedge clk); sw[1] = 1'b1;
    cycles(15, "sw1_in_hold");
    @(negedge clk); ack = 1'b1;
    cycles(1, "sw4_ack");
    @(negedge clk); ack = 1'b0;
    cycles(1, "after_gap");
    after_gap = QEN ? 4'h1 : 4'hF;
    expect_int("after_gap_code", int'(change), int'(after_gap));
    @(negedge clk); ack = 1'b1;
    cycles(1, "clear");
    @(negedge clk); ack = 1'b0;
    cycles(5, "settle");

    @(negedge clk); sw[9] = 1'b1;
    wait_pending(20, "sw9", lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); sw[qlist[i]] = ~sw[qlist[i]];
      cycles(10, "burst");
    end
`ifdef SWDET_QUEUE_EN
    expect_int("overflow_set", int'(overflow), 1);
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); ack = pending;
      cycles(1, "drain");
    end
    @(negedge clk); ack = 1'b0;
    cycles(3, "drained");

    @(negedge clk); en = 1'b0; sw[0] = 1'b1;
    ev_seen = 0;
    cycles(20, "disabled");
    expect_int("disabled_no_event", ev_seen, 0);
    @(negedge clk); en = 1'b1; sw[0] = 1'b0;
    wait_pending(20, "sw0", lat);
    expect_int("code_sw0", int'(change), 0);

    // Reset between edges while a code is held: outputs drop immediately.
    cycles(3, "pre_reset");
    #2 rst_n = 1'b0;
    #1 check_all("async_reset");
    expect_int("async_reset_code", int'(change), 15);
    @(negedge clk); rst_n = 1'b1;

    for (int c = 0; c < 2500; c++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 15);
      if (r == 0) sw[$urandom_range(0, NUM_SW - 1)] ^= 1'b1;
      if (r == 1) begin
        sw[$urandom_range(0, 4)] ^= 1'b1;
        sw[$urandom_range(5, NUM_SW - 1)] ^= 1'b1;
      end
      if ($urandom_range(0, 63) == 0) en = ~en;
      ack = ($urandom_range(0, 15) == 0);
      cycles(1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
